// File: rtl/grid_clb_param.sv
// grid_clb_param: parametrised CLB tile with N BLEs (K-LUT plus optional flop),
// a per-LUT-input local crossbar and a serial configuration chain with a
// load-length counter that reports when a complete bitstream has been shifted in.
module grid_clb_param #(
  parameter int N = 4,
  parameter int K = 4,
  parameter int I = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         prog_en,
  input  logic         ccff_head,
  input  logic [I-1:0] clb_I,
  input  logic         clb_en,
  output logic [N-1:0] clb_O,
  output logic         ccff_tail,
  output logic         cfg_valid
);

  localparam int SELW     = $clog2(I + N);
  localparam int LUTW     = 1 << K;
  localparam int BLE_BITS = LUTW + K * SELW + 1;
  localparam int CFG_BITS = N * BLE_BITS;
  localparam int CNTW     = $clog2(CFG_BITS + 1);
  localparam int SRCW     = 1 << SELW;
  localparam int RMOFS    = LUTW + K * SELW;

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                prog_en_q, prog_en_d;
  logic [N-1:0]        ff_q, ff_d;

  logic [N-1:0]        reg_mode;
  logic [N-1:0]        lut_out;
  logic [N-1:0]        ble_out;
  logic [SRCW-1:0]     src;
  logic [K-1:0]        lut_idx;
  logic [LUTW-1:0]     truth_v;
  logic [SELW-1:0]     sel_v;

  // BLE evaluation: crossbar, LUT lookup and output select for every BLE.
  // Feedback is resolved by N unrolled passes instead of a structural loop:
  // a loop-free bitstream has combinational depth below N, so the last pass
  // holds the settled values.
  always_comb begin
    reg_mode = '0;
    for (int unsigned j = 0; j < N; j++) begin
      reg_mode[j] = cfg_q[j * BLE_BITS + RMOFS];
    end
    lut_out = '0;
    lut_idx = '0;
    truth_v = '0;
    sel_v   = '0;
    src     = '0;
    ble_out = ff_q & reg_mode;
    for (int unsigned pass = 0; pass < N; pass++) begin
      src = '0;
      src[I+N-1:0] = {ble_out, clb_I};
      for (int unsigned j = 0; j < N; j++) begin
        for (int unsigned k = 0; k < K; k++) begin
          sel_v      = cfg_q[j * BLE_BITS + LUTW + k * SELW +: SELW];
          lut_idx[k] = src[sel_v];
        end
        truth_v    = cfg_q[j * BLE_BITS +: LUTW];
        lut_out[j] = truth_v[lut_idx];
      end
      ble_out = (ff_q & reg_mode) | (lut_out & ~reg_mode);
    end
  end

  // Next-state for config chain, load counter and user flops.
  always_comb begin
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    prog_en_d = prog_en;
    ff_d      = ff_q;
    if (prog_en) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
      if (!prog_en_q) begin
        cnt_d = CNTW'(1);
      end else if (cnt_q != CNTW'(CFG_BITS)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (clb_en) begin
      ff_d = lut_out;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q     <= '0;
      cnt_q     <= '0;
      prog_en_q <= 1'b0;
      ff_q      <= '0;
    end else begin
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      prog_en_q <= prog_en_d;
      ff_q      <= ff_d;
    end
  end

  assign clb_O     = prog_en ? '0 : ble_out;
  assign ccff_tail = cfg_q[CFG_BITS-1];
  assign cfg_valid = (cnt_q == CNTW'(CFG_BITS)) && !prog_en_q;

endmodule

// File: tb/tb_grid_clb_param.sv
// tb_grid_clb_param: directed bench for grid_clb_param with a bit-history
// model of the configuration chain and a settle-until-stable BLE evaluator.
module tb_grid_clb_param;

  localparam int N        = 4;
  localparam int K        = 4;
  localparam int I        = 10;
  localparam int SELW     = $clog2(I + N);
  localparam int LUTW     = 1 << K;
  localparam int BLE_BITS = LUTW + K * SELW + 1;
  localparam int CFG      = N * BLE_BITS;

  logic         clk;
  logic         reset;
  logic         prog_en;
  logic         ccff_head;
  logic [I-1:0] clb_I;
  logic         clb_en;
  logic [N-1:0] clb_O;
  logic         ccff_tail;
  logic         cfg_valid;

  int n_cmp = 0;
  int n_bad = 0;

  grid_clb_param #(.N(N), .K(K), .I(I)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_en   (prog_en),
    .ccff_head (ccff_head),
    .clb_I     (clb_I),
    .clb_en    (clb_en),
    .clb_O     (clb_O),
    .ccff_tail (ccff_tail),
    .cfg_valid (cfg_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit           m_hist[$];   // bits shifted in, oldest first
  logic [N-1:0] m_ff;
  int           m_len;       // length of current/last load
  bit           m_prev;      // prog_en at previous edge
  logic [N-1:0] m_luts_t;

  function automatic bit cfg_bit(input int i);
    int n;
    n = m_hist.size();
    if (i < n) return m_hist[n - 1 - i];
    return 1'b0;
  endfunction

  function automatic int field(input int pos, input int w);
    int v;
    v = 0;
    for (int b = 0; b < w; b++) if (cfg_bit(pos + b)) v |= (1 << b);
    return v;
  endfunction

  function automatic logic [N-1:0] regmask();
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j] = cfg_bit(j * BLE_BITS + LUTW + K * SELW);
    return r;
  endfunction

  function automatic logic [N-1:0] lut_all(input logic [N-1:0] bo);
    logic [N-1:0] r;
    int base, idx, s;
    bit v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      base = j * BLE_BITS;
      idx  = 0;
      for (int k = 0; k < K; k++) begin
        s = field(base + LUTW + k * SELW, SELW);
        if (s < I) v = clb_I[s];
        else if (s < I + N) v = bo[s - I];
        else v = 1'b0;
        if (v) idx |= (1 << k);
      end
      r[j] = cfg_bit(base + idx);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] settle();
    logic [N-1:0] rm, bo, nb;
    rm = regmask();
    bo = m_ff & rm;
    for (int it = 0; it < 2 * N + 2; it++) begin
      nb = (m_ff & rm) | (lut_all(bo) & ~rm);
      if (nb == bo) break;
      bo = nb;
    end
    return bo;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist.delete();
      m_ff   = '0;
      m_len  = 0;
      m_prev = 1'b0;
    end else begin
      m_luts_t = lut_all(settle());
      if (prog_en) begin
        m_hist.push_back(ccff_head);
        if (m_hist.size() > CFG) void'(m_hist.pop_front());
        m_len = m_prev ? m_len + 1 : 1;
      end else if (clb_en) begin
        m_ff = m_luts_t;
      end
      m_prev = prog_en;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    check("model_clb_O", 32'(clb_O), 32'(prog_en ? '0 : settle()));
    check("model_tail", 32'(ccff_tail), 32'(cfg_bit(CFG - 1)));
    check("model_valid", 32'(cfg_valid), 32'((m_len >= CFG) && !m_prev));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [CFG-1:0] set_ble(input logic [CFG-1:0] img, input int j,
                                             input logic [LUTW-1:0] truth,
                                             input int s0, input int s1, input int s2,
                                             input int s3, input bit rm);
    int b;
    int s[4];
    b = j * BLE_BITS;
    s = '{s0, s1, s2, s3};
    for (int t = 0; t < LUTW; t++) img[b + t] = truth[t];
    for (int k = 0; k < K; k++)
      for (int t = 0; t < SELW; t++) img[b + LUTW + k * SELW + t] = s[k][t];
    img[b + LUTW + K * SELW] = rm;
    return img;
  endfunction

  task automatic shift1(input bit b);
    @(negedge clk);
    prog_en   = 1'b1;
    ccff_head = b;
  endtask

  task automatic shift_end();
    @(negedge clk);
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic shift_img(input logic [CFG-1:0] img, input int from);
    for (int i = from; i >= 0; i--) shift1(img[i]);
  endtask

  logic [CFG-1:0] img2, img3, img4;

  initial begin
    reset = 1'b1; prog_en = 1'b0; ccff_head = 1'b0; clb_I = '0; clb_en = 1'b0;
    img2 = set_ble('0, 0, 16'h8000, 0, 1, 2, 3, 1'b0);
    img3 = set_ble('0, 0, 16'h8000, 0, 1, 2, 3, 1'b1);
    img4 = set_ble('0, 1, 16'h5555, I + 1, 15, 15, 15, 1'b1);

    // Test 1: reset state, reset mid-shift, restart of the counter
    @(negedge clk); @(negedge clk);
    check("rst_clb_O", 32'(clb_O), 32'h0);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) shift1(1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_clb_O", 32'(clb_O), 32'h0);
    check("midrst_tail", 32'(ccff_tail), 32'h0);
    check("midrst_valid", 32'(cfg_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0; prog_en = 1'b0;
    for (int i = 0; i < 90; i++) shift1(1'b1);
    shift_end();
    @(posedge clk); #2;
    check("restart_valid", 32'(cfg_valid), 32'h0);

    // Test 2: full load, combinational AND4 on BLE0
    shift_img(img2, CFG - 1);
    shift_end();
    #3;
    check("t2_valid_lag", 32'(cfg_valid), 32'h0);
    @(posedge clk); #2;
    check("t2_valid", 32'(cfg_valid), 32'h1);
    @(negedge clk);
    clb_I = 10'h00F; #3;
    check("t2_and_F", 32'(clb_O), 32'h1);
    clb_I = 10'h00E; #3;
    check("t2_and_E", 32'(clb_O), 32'h0);
    clb_I = 10'h3EF; #3;
    check("t2_and_3EF", 32'(clb_O), 32'h1);

    // Test 3: registered AND4; clb_O masked while shifting
    @(negedge clk);
    clb_I = 10'h00F; #2;
    check("t3_pre_mask", 32'(clb_O), 32'h1);
    shift1(img3[CFG - 1]); #2;
    check("t3_mask", 32'(clb_O), 32'h0);
    shift_img(img3, CFG - 2);
    shift_end();
    @(posedge clk); @(posedge clk); #2;
    check("t3_en0", 32'(clb_O), 32'h0);
    @(negedge clk);
    clb_en = 1'b1;
    @(posedge clk); #2;
    check("t3_en1", 32'(clb_O), 32'h1);
    @(negedge clk);
    clb_I = 10'h00E; #3;
    check("t3_hold", 32'(clb_O), 32'h1);
    @(posedge clk); #2;
    check("t3_clr", 32'(clb_O), 32'h0);
    @(negedge clk);
    clb_en = 1'b0;

    // Test 4: BLE1 registered inverter on its own output
    shift_img(img4, CFG - 1);
    shift_end();
    #3;
    check("t4_init", 32'(clb_O), 32'h0);
    @(negedge clk);
    clb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("t4_toggle", 32'(clb_O), (i % 2 == 0) ? 32'h2 : 32'h0);
    end
    @(negedge clk);
    clb_en = 1'b0;

    // Test 5: pass-through of 132 ones then 132 zeros
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 2 * CFG; k++) begin
      shift1(k <= CFG);
      @(posedge clk); #2;
      if (k == CFG - 1)     check("t5_tail_131", 32'(ccff_tail), 32'h0);
      if (k == CFG)         check("t5_tail_132", 32'(ccff_tail), 32'h1);
      if (k == 2 * CFG - 1) check("t5_tail_263", 32'(ccff_tail), 32'h1);
      if (k == 2 * CFG)     check("t5_tail_264", 32'(ccff_tail), 32'h0);
      if (k == 200)         check("t5_clb_O", 32'(clb_O), 32'h0);
    end
    shift_end();
    @(posedge clk); #2;
    check("t5_valid", 32'(cfg_valid), 32'h1);

    // Test 6: short load then over-length load
    shift1(1'b0); #3;
    check("t6_valid_hold", 32'(cfg_valid), 32'h1);
    @(posedge clk); #2;
    check("t6_valid_drop", 32'(cfg_valid), 32'h0);
    for (int i = 1; i < 100; i++) shift1(1'b0);
    shift_end();
    @(posedge clk); @(posedge clk); #2;
    check("t6_short", 32'(cfg_valid), 32'h0);
    for (int i = 0; i < 8; i++) shift1(1'b1);
    shift_img(img2, CFG - 1);
    shift_end();
    @(posedge clk); #2;
    check("t6_long_valid", 32'(cfg_valid), 32'h1);
    @(negedge clk);
    clb_I = 10'h00F; #3;
    check("t6_and_F", 32'(clb_O), 32'h1);
    clb_I = 10'h00E; #3;
    check("t6_and_E", 32'(clb_O), 32'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
